// File: rtl/bc_band_collect_pkg.sv
// Shared types and constants for the band frame collector.
// The frame holds one sample per filter-bank band, band 0 in the low slice.
package bc_pkg;

  localparam int BC_N      = 8;
  localparam int BC_PHASES = 4;

  typedef logic [BC_N-1:0]       bc_sample_t;
  typedef bc_sample_t [3:0]      bc_frame_t;
  typedef logic [1:0]            bc_phase_t;

endpackage

// File: rtl/bc_frame_fifo.sv
// Synchronous frame FIFO with separate occupancy counter and cleared storage.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module bc_frame_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is reset so the head output reads as zero out of reset;
  // this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bc_band_collect.sv
// Collects the filter bank's time-multiplexed sub-band samples into aligned
// 4-band frames on a free-running 4-phase schedule and queues them for output.
module bc_band_collect
  import bc_pkg::*;
#(
  parameter  int N           = BC_N,
  parameter  int DEPTH       = 4,
  parameter  int SKIP_FRAMES = 0,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [4*N-1:0] in,
  output logic [4*N-1:0] out_frame,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           clr_ovf,
  output logic           overflow,
  output logic [LW-1:0]  level
);

  localparam bc_phase_t LAST_PHASE = bc_phase_t'(BC_PHASES - 1);

  bc_phase_t      phase;
  logic [N-1:0]   hold [3];
  logic [7:0]     skip_cnt;
  logic           frame_done;
  logic           take;
  logic           pop;
  logic           push;
  logic           drop;
  logic           full;
  logic           empty;
  logic [4*N-1:0] wdata;

  assign frame_done = (phase == LAST_PHASE);
  assign take       = frame_done && (skip_cnt == 8'd0);
  assign pop        = out_valid && out_ready;
  // A pop in the same cycle frees the slot the completed frame needs.
  assign push       = take && (!full || pop);
  assign drop       = take && full && !pop;
  assign out_valid  = !empty;
  // Band 3 is taken straight from the bus in the phase it arrives.
  assign wdata      = {in[4*N-1:3*N], hold[2], hold[1], hold[0]};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      for (int k = 0; k < 3; k++) hold[k] <= '0;
      skip_cnt <= 8'(SKIP_FRAMES);
      overflow <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      for (int k = 0; k < 3; k++)
        if (phase == bc_phase_t'(k)) hold[k] <= in[k*N +: N];
      if (frame_done && skip_cnt != 8'd0) skip_cnt <= skip_cnt - 8'd1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  bc_frame_fifo #(
    .WIDTH (4*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (out_frame),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_bc_band_collect.sv
// Bench for bc_band_collect: two instances (no skip, skip 2) driven in parallel,
// a queue-based frame model checked every cycle, plus hand-computed expectations.
module tb_bc_band_collect;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int W     = 4 * N;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_bus = '0;
  logic          out_ready = 1'b0;
  logic          clr_ovf = 1'b0;

  logic [W-1:0]  o_frame [2];
  logic          o_valid [2];
  logic          o_ovf   [2];
  logic [LW-1:0] o_level [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  bc_band_collect #(.N(N), .DEPTH(DEPTH), .SKIP_FRAMES(0)) dut (
    .clock(clock), .reset(reset), .in(in_bus),
    .out_frame(o_frame[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .overflow(o_ovf[0]), .level(o_level[0])
  );

  bc_band_collect #(.N(N), .DEPTH(DEPTH), .SKIP_FRAMES(2)) dut_skip (
    .clock(clock), .reset(reset), .in(in_bus),
    .out_frame(o_frame[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .overflow(o_ovf[1]), .level(o_level[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Band k in cycle c carries {k+1 : high nibble, phase : low bits} plus 4*frame.
  function automatic logic [W-1:0] sample_word(input int c);
    logic [W-1:0] w;
    int p, f;
    p = c % 4;
    f = c / 4;
    for (int k = 0; k < 4; k++) w[k*N +: N] = 8'((k + 1) * 16 + p + 4 * f);
    return w;
  endfunction

  task automatic step(input logic rdy, input logic clr);
    out_ready = rdy;
    clr_ovf   = clr;
    in_bus    = sample_word(cyc);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Model: cycles since reset give the phase; frames go through a plain queue.
  logic [W-1:0] mq [2][$];
  int           mskip [2];
  bit           movf  [2];
  logic [N-1:0] mband [3];
  int           mt;
  int           skip_cfg [2] = '{0, 2};

  always @(negedge clock) begin
    int  p;
    bit  pop;
    bit  drop;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check("rst_valid", 32'(o_valid[i]), 32'd0);
        check("rst_level", 32'(o_level[i]), 32'd0);
        check("rst_ovf",   32'(o_ovf[i]),   32'd0);
        check("rst_frame", o_frame[i],      32'd0);
        mq[i].delete();
        mskip[i] = skip_cfg[i];
        movf[i]  = 1'b0;
      end
      for (int k = 0; k < 3; k++) mband[k] = '0;
      mt = 0;
    end else begin
      p = mt % 4;
      for (int i = 0; i < 2; i++) begin
        check("m_valid", 32'(o_valid[i]), 32'(mq[i].size() != 0));
        check("m_level", 32'(o_level[i]), 32'(mq[i].size()));
        check("m_ovf",   32'(o_ovf[i]),   32'(movf[i]));
        if (mq[i].size() != 0) check("m_frame", o_frame[i], mq[i][0]);
        pop  = (mq[i].size() != 0) && out_ready;
        drop = 1'b0;
        if (pop) void'(mq[i].pop_front());
        if (p == 3) begin
          if (mskip[i] > 0) mskip[i]--;
          else if (mq[i].size() < DEPTH)
            mq[i].push_back({in_bus[W-1:3*N], mband[2], mband[1], mband[0]});
          else drop = 1'b1;
        end
        if (drop)         movf[i] = 1'b1;
        else if (clr_ovf) movf[i] = 1'b0;
      end
      if (p < 3) mband[p] = in_bus[p*N +: N];
      mt++;
    end
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_valid", 32'(o_valid[i]), 32'd0);
      check("reset_frame", o_frame[i],      32'd0);
    end
    reset = 1'b1;
    cyc   = 0;

    // First frame appears in cycle 4.
    repeat (4) step(1'b1, 1'b0);
    check("first_valid", 32'(o_valid[0]), 32'd1);
    check("first_frame", o_frame[0], 32'h43322110);
    check("skip_not_valid", 32'(o_valid[1]), 32'd0);

    // Skipping instance: first delivered frame is frame 2.
    repeat (8) step(1'b1, 1'b0);
    check("skip_first_valid", 32'(o_valid[1]), 32'd1);
    check("skip_first_frame", o_frame[1], 32'h4B3A2918);

    // Stall: fill to 4, drop frame 6 while clr_ovf is high in the same cycle.
    repeat (15) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("ovf_set_beats_clr", 32'(o_ovf[0]), 32'd1);
    check("full_level", 32'(o_level[0]), 32'd4);
    check("head_stable", o_frame[0], 32'h4B3A2918);
    step(1'b0, 1'b1);
    check("ovf_cleared", 32'(o_ovf[0]), 32'd0);

    // Full FIFO, pop in the phase-3 cycle: push accepted, no overflow.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("fullpush_level", 32'(o_level[0]), 32'd4);
    check("fullpush_ovf", 32'(o_ovf[0]), 32'd0);
    check("fullpush_head", o_frame[0], 32'h4F3E2D1C);
    step(1'b1, 1'b0);
    check("three_stored", 32'(o_level[0]), 32'd3);

    // Reset in phase 2 with 3 frames stored.
    step(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_valid", 32'(o_valid[i]), 32'd0);
      check("async_level", 32'(o_level[i]), 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
    repeat (3) step(1'b1, 1'b0);
    check("rerun_not_yet", 32'(o_valid[0]), 32'd0);
    step(1'b1, 1'b0);
    check("rerun_valid", 32'(o_valid[0]), 32'd1);
    check("rerun_frame", o_frame[0], 32'h43322110);
    check("rerun_skip_reloaded", 32'(o_valid[1]), 32'd0);
    repeat (4) step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bc_band_collect.md
# bc_band_collect

Frame collector that sits directly downstream of the time-multiplexed binary filter bank. It samples the bank's 4×N-bit packed sub-band output on a fixed 4-phase schedule and assembles one aligned 4-band frame per 4-cycle period. Completed frames are buffered in a small FIFO and delivered to the next stage over a valid/ready handshake. Frames are dropped on overflow, with a sticky flag.

## Interface
- `N`, 8: sample width per band, in bits.
- `DEPTH`, 4: FIFO depth in frames; must be a power of 2 and ≥2.
- `SKIP_FRAMES`, 0: number of frames discarded after reset while the bank's delay lines fill (0–255).

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  4N  bank output; band k occupies `in[(k+1)N-1:kN]`.
- `out_frame`  out  4N  head frame; band k is in the same bit slice as on `in`.
- `out_valid`  out  1  head frame is valid.
- `out_ready`  in  1  consumer accepts the head frame.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `overflow`  out  1  sticky flag: at least one frame was dropped.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Phase counter:
  - 2-bit, free-running, 0→1→2→3→0.
  - Value is 0 in the first cycle after `reset` deasserts, so it tracks the bank's own 2-bit counter when both leave reset together.
- Capture:
  - In phase k, slice k of `in` is registered into hold register k.
  - In phase 3, hold registers 0–2 and `in` slice 3 form the completed frame. Slice 3 goes straight to the FIFO, not via hold register 3.
- Skip counter:
  - 8-bit, loaded with `SKIP_FRAMES` at reset, decremented per completed frame until it reaches 0.
  - While it is nonzero, completed frames are discarded: no push, no overflow set.
- FIFO:
  - `DEPTH` entries of 4N bits.
  - Write and read pointers are clog2(DEPTH) bits and wrap naturally.
  - Occupancy counter is kept separately.
- Push: a completed, non-skipped frame is written when `level < DEPTH`. If `level == DEPTH` and no pop occurs that cycle, the frame is dropped and `overflow` is set.
- Pop: `out_valid && out_ready`. Advances the read pointer and decrements `level`.
- Push and pop in the same cycle:
  - Both take effect and `level` is unchanged.
  - When full, the pop frees a slot and the push is accepted; no overflow.
- `out_valid = (level != 0)`. `out_frame` is driven from the RAM entry at the read pointer.
- `out_frame` is stable while `out_valid && !out_ready`. Head data never changes until it is popped.
- `overflow`:
  - Set has priority over `clr_ovf` in the same cycle.
  - Cleared only by `clr_ovf` or `reset`.
- Arithmetic: samples pass through bit-exact, with no sign extension, rounding or saturation.

## Timing
- Reset values:
  - phase = 0; hold registers, pointers and `level` = 0.
  - `out_valid` = 0, `overflow` = 0, `out_frame` = 0 (FIFO storage is cleared).
  - Skip counter = `SKIP_FRAMES`.
- Latency: the frame is written at the rising edge ending the phase-3 cycle. With an empty FIFO, `out_valid` = 1 with that frame in the next cycle.
- Throughput: at most 1 frame per 4 cycles in, and 1 frame per cycle out.
- Reset asserted mid-frame: partially captured bands are lost. After release, capture restarts at phase 0 and any stored frames are discarded.

## Structure
- Package `bc_pkg`:
  - `BC_N`.
  - `typedef logic [BC_N-1:0] bc_sample_t`.
  - `typedef bc_sample_t [3:0] bc_frame_t`.
  - `BC_PHASES = 4`.
- One sub-module, `bc_frame_fifo`: parameterised sync FIFO with push/pop, `level` and full/empty. The top level holds the phase counter, hold registers, skip counter and overflow logic.

## Test plan
- Reset release, then drive in = {8'h40|p, 8'h30|p, 8'h20|p, 8'h10|p} in phase p. Required: `out_valid` rises in cycle 4 with `out_frame` = 32'h43322110, and `out_ready` = 1 pops it.
- Hold `out_ready` = 0 with `DEPTH` = 4 for 5 periods. Required: `level` reaches 4, the 5th frame is dropped, `overflow` = 1, and the head frame is unchanged.
- Full FIFO with `out_ready` = 1 in the phase-3 cycle. Required: push is accepted, `level` stays 4, `overflow` stays 0.
- With `SKIP_FRAMES` = 2, frames 0 and 1 are never output. Required: the first `out_frame` equals frame 2's data and `level` never exceeds 1 while `out_ready` = 1.
- `clr_ovf` asserted in the same cycle as an overflow drop. Required: `overflow` remains 1. A `clr_ovf` pulse in the next cycle clears it.
- Assert `reset` in phase 2 with 3 frames stored. Required: `out_valid` = 0 and `level` = 0 immediately, asynchronously. After release, the next frame appears 4 cycles later.
